// File: rtl/otp_serial_cipher_ctrl.sv
// Serial one-time-pad cipher controller: buffers one plaintext and one key word,
// XORs them bit-serially LSB-first, and holds the ciphertext until consumed.
module otp_serial_cipher_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     key_valid,
    output logic                     key_ready,
    input  logic [WIDTH-1:0]         key_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     busy,
    output logic [$clog2(WIDTH):0]   bit_count,
    output logic [CNT_W-1:0]         words_done
);

    localparam int BC_W = $clog2(WIDTH) + 1;
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  pt_q;
    logic [WIDTH-1:0]  key_q;
    logic [WIDTH-1:0]  out_data_q;
    logic              data_full_q;
    logic              key_full_q;
    logic              in_ready_q;
    logic              key_ready_q;
    logic              out_valid_q;
    logic              busy_q;
    logic [BC_W-1:0]   bit_cnt_q;
    logic [CNT_W-1:0]  words_q;

    logic              take_data;
    logic              take_key;
    logic              data_full_d;
    logic              key_full_d;
    logic              cipher_bit;
    logic [WIDTH-1:0]  pt_d;

    // The plaintext register doubles as the output shift register: each cipher
    // bit enters at the MSB while the consumed plaintext bit leaves at the LSB.
    always_comb begin
        take_data   = in_valid && in_ready_q;
        take_key    = key_valid && key_ready_q;
        data_full_d = data_full_q || take_data;
        key_full_d  = key_full_q || take_key;
        cipher_bit  = pt_q[0] ^ key_q[0];
        pt_d        = {cipher_bit, pt_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pt_q        <= '0;
            key_q       <= '0;
            out_data_q  <= '0;
            data_full_q <= 1'b0;
            key_full_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            key_ready_q <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            bit_cnt_q   <= '0;
            words_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (take_data) pt_q <= in_data;
                    if (take_key) key_q <= key_data;
                    data_full_q <= data_full_d;
                    key_full_q  <= key_full_d;
                    if (data_full_d && key_full_d) begin
                        state_q     <= SHIFT;
                        busy_q      <= 1'b1;
                        bit_cnt_q   <= '0;
                        in_ready_q  <= 1'b0;
                        key_ready_q <= 1'b0;
                    end else begin
                        in_ready_q  <= !data_full_d;
                        key_ready_q <= !key_full_d;
                    end
                end
                SHIFT: begin
                    pt_q      <= pt_d;
                    key_q     <= key_q >> 1;
                    bit_cnt_q <= bit_cnt_q + BC_W'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        out_data_q  <= pt_d;
                    end
                end
                DONE: begin
                    // Clearing both buffers on delivery is what makes the key single-use.
                    if (out_ready) begin
                        state_q     <= IDLE;
                        words_q     <= words_q + CNT_W'(1);
                        pt_q        <= '0;
                        key_q       <= '0;
                        data_full_q <= 1'b0;
                        key_full_q  <= 1'b0;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        bit_cnt_q   <= '0;
                        in_ready_q  <= 1'b1;
                        key_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign key_ready  = key_ready_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign busy       = busy_q;
    assign bit_count  = bit_cnt_q;
    assign words_done = words_q;

endmodule

// File: tb/tb_otp_serial_cipher_ctrl.sv
// Bench for otp_serial_cipher_ctrl: directed cases plus randomized words checked
// against a word-level model (cipher = plaintext ^ key, delivery count modulo 2^CNT_W).
module tb_otp_serial_cipher_ctrl;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data = '0;
    logic              key_valid = 1'b0;
    logic              key_ready;
    logic [WIDTH-1:0]  key_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [WIDTH-1:0]  out_data;
    logic              busy;
    logic [3:0]        bit_count;
    logic [CNT_W-1:0]  words_done;

    int total = 0;
    int bad = 0;
    int exp_words = 0;

    otp_serial_cipher_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_data   (key_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .bit_count  (bit_count),
        .words_done (words_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_after_reset();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_key_ready", key_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_bit_count", bit_count, 0);
        chk("rst_words_done", words_done, 0);
    endtask

    // Offer both words with the given delays, holding valid until accepted.
    // Returns with both words accepted (just after the filling edge) or ok=0.
    task automatic offer(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] k,
                         input int pd, input int kd, output bit ok);
        bit pdone = 0;
        bit kdone = 0;
        bit ap;
        bit ak;
        int cyc = 0;
        ok = 1;
        while (!(pdone && kdone)) begin
            in_valid  = !pdone && (cyc >= pd);
            in_data   = p;
            key_valid = !kdone && (cyc >= kd);
            key_data  = k;
            ap = in_valid && in_ready;
            ak = key_valid && key_ready;
            tick();
            if (ap) pdone = 1;
            if (ak) kdone = 1;
            if (kdone && !pdone) chk("key_ready_waiting", key_ready, 0);
            if (pdone && !kdone) chk("in_ready_waiting", in_ready, 0);
            cyc++;
            if (cyc > 60) begin
                chk("accept_timeout", 1, 0);
                ok = 0;
                break;
            end
        end
        in_valid  = 1'b0;
        key_valid = 1'b0;
    endtask

    task automatic run_word(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] k,
                            input int pd, input int kd, input int stall);
        bit ok;
        logic [WIDTH-1:0] exp_c;
        exp_c = p ^ k;
        offer(p, k, pd, kd, ok);
        if (!ok) return;
        chk("fill_busy", busy, 1);
        chk("fill_in_ready", in_ready, 0);
        chk("fill_key_ready", key_ready, 0);
        chk("fill_bit_count", bit_count, 0);
        for (int n = 1; n <= WIDTH; n++) begin
            in_valid = 1'b1;
            key_valid = 1'b1;
            tick();
            chk("latency_out_valid", out_valid, (n == WIDTH) ? 1 : 0);
        end
        in_valid = 1'b0;
        key_valid = 1'b0;
        chk("cipher", out_data, exp_c);
        for (int s = 0; s < stall; s++) begin
            tick();
            chk("stall_out_valid", out_valid, 1);
            chk("stall_out_data", out_data, exp_c);
            chk("stall_readies", {in_ready, key_ready}, 0);
            chk("stall_busy", busy, 1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        exp_words = (exp_words + 1) % (1 << CNT_W);
        chk("deliver_out_valid", out_valid, 0);
        chk("deliver_words_done", words_done, exp_words);
        chk("deliver_busy", busy, 0);
        chk("deliver_readies", {in_ready, key_ready}, 2'b11);
        chk("idle_out_data_kept", out_data, exp_c);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        // Test 1: two-cycle reset
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_idle_after_reset();

        // Test 2: same-edge arrival
        run_word(8'hA5, 8'h3C, 0, 0, 0);
        // Test 3: key first, plaintext three cycles later
        run_word(8'h0F, 8'hFF, 3, 0, 1);
        // Test 4: consumer stalls five cycles
        run_word(8'h5A, 8'hC3, 1, 2, 5);

        for (int i = 0; i < 20; i++) begin
            run_word(WIDTH'($urandom), WIDTH'($urandom), int'($urandom_range(0, 4)),
                     int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
        end

        // Test 5: reset in the middle of shifting
        offer(8'h77, 8'h12, 0, 0, ok);
        repeat (3) tick();
        chk("mid_bit_count", bit_count, 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_words = 0;
        check_idle_after_reset();
        for (int n = 0; n < 12; n++) begin
            tick();
            chk("post_rst_no_valid", out_valid, 0);
        end

        // Test 6: counter wrap over 17 back-to-back deliveries
        for (int i = 1; i <= 17; i++) begin
            run_word(WIDTH'($urandom), WIDTH'($urandom), 0, 0, 0);
            if (i == 16) chk("wrap_16", words_done, 0);
            if (i == 17) chk("wrap_17", words_done, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
